// File: rtl/rf_sequencer.sv
// rf_sequencer: control unit for the 16x16 register-file datapath.
//
// Fetches 16-bit instructions from a synchronous instruction ROM, decodes
// them and drives the register-file read/write ports, the ALU select, the
// data-RAM address/write strobe and the write-back mux. PC and IR are held
// here. Outputs are Moore: they depend only on the registered state and IR.
//
// Ports
//   Clk         system clock, rising-edge active
//   Reset       synchronous active-high reset
//   IM_data     instruction ROM read data for PC_addr (captured in FETCH)
//   PC_addr     instruction ROM address (= PC)
//   IR          current instruction register (debug)
//   D_addr      data RAM address
//   D_wr        data RAM write enable
//   RF_s        write-back mux select: 1 = RAM read data, 0 = ALU result
//   RF_W_addr   register-file write address
//   RF_W_en     register-file write enable
//   RF_Ra_addr  read port 0 address
//   RF_Ra_en    read port 0 enable
//   RF_Rb_addr  read port 1 address
//   RF_Rb_en    read port 1 enable
//   ALU_s       ALU op: 000 idle, 001 add, 010 sub
//   Halted      high while in HALT
//   State       encoded current state (debug)
module rf_sequencer #(
  parameter int PC_WIDTH = 7
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [15:0]         IM_data,
  output logic [PC_WIDTH-1:0] PC_addr,
  output logic [15:0]         IR,
  output logic [7:0]          D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic [3:0]          RF_W_addr,
  output logic                RF_W_en,
  output logic [3:0]          RF_Ra_addr,
  output logic                RF_Ra_en,
  output logic [3:0]          RF_Rb_addr,
  output logic                RF_Rb_en,
  output logic [2:0]          ALU_s,
  output logic                Halted,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  state_t              state_q;
  state_t              state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir_q;

  // State register; PC and IR only move in FETCH, so HALT freezes both.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        ir_q <= IM_data;
        pc_q <= pc_q + 1'b1;  // wraps naturally at 2^PC_WIDTH
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;  // 0000 and 0110-1111
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      S_ADD:    state_d = S_FETCH;
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Moore outputs. Reads and the write of the same register may coincide in
  // the exec cycle; the register file returns the pre-write value, so no
  // stall is needed here.
  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Ra_en   = 1'b0;
    RF_Rb_addr = '0;
    RF_Rb_en   = 1'b0;
    ALU_s      = 3'b000;
    Halted     = 1'b0;
    case (state_q)
      // RAM has one cycle of read latency: address is presented in LOAD_A
      // and held in LOAD_B while the returned data is written back.
      S_LOAD_A: begin
        D_addr = ir_q[11:4];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = ir_q[7:0];
        D_wr       = 1'b1;
        RF_Ra_addr = ir_q[11:8];
        RF_Ra_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[11:8];
        RF_Ra_en   = 1'b1;
        RF_Rb_addr = ir_q[7:4];
        RF_Rb_en   = 1'b1;
        ALU_s      = (state_q == S_ADD) ? 3'b001 : 3'b010;
        RF_W_addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_addr = pc_q;
  assign IR      = ir_q;
  assign State   = state_q;

endmodule

// File: tb/tb_rf_sequencer.sv
module tb_rf_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IM_data;
  logic [6:0]  PC_addr;
  logic [15:0] IR;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic        RF_Ra_en;
  logic [3:0]  RF_Rb_addr;
  logic        RF_Rb_en;
  logic [2:0]  ALU_s;
  logic        Halted;
  logic [3:0]  State;

  logic [15:0] rom [128];
  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  assign IM_data = rom[PC_addr];

  rf_sequencer #(.PC_WIDTH(7)) dut (
    .Clk(Clk), .Reset(Reset), .IM_data(IM_data), .PC_addr(PC_addr), .IR(IR),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr),
    .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr), .RF_Ra_en(RF_Ra_en),
    .RF_Rb_addr(RF_Rb_addr), .RF_Rb_en(RF_Rb_en), .ALU_s(ALU_s),
    .Halted(Halted), .State(State)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model: which cycle of the current instruction we are in
  // (0 fetch, 1 decode, 2 first exec, 3 second exec for LOAD), plus PC/IR.
  bit          m_valid = 1'b0;
  bit          m_init;
  bit          m_halt;
  int          m_step;
  logic [6:0]  m_pc;
  logic [15:0] m_ir;
  logic [55:0] m_exp;

  function automatic logic [55:0] model_outputs(bit init, bit halt, int step,
                                                logic [15:0] ir, logic [6:0] pc);
    logic [3:0] st, op, w, ra, rb;
    logic       hal, rb_en, ra_en, w_en, rfs, dwr;
    logic [2:0] alu;
    logic [7:0] da;
    st = 0; hal = 0; alu = 0; rb_en = 0; rb = 0; ra_en = 0; ra = 0;
    w_en = 0; w = 0; rfs = 0; dwr = 0; da = 0;
    op = ir[15:12];
    if (init) st = 4'd0;
    else if (halt) begin st = 4'd9; hal = 1; end
    else if (step == 0) st = 4'd1;
    else if (step == 1) st = 4'd2;
    else if (step == 3) begin
      st = 4'd5; da = ir[11:4]; rfs = 1; w = ir[3:0]; w_en = 1;
    end else begin
      if (op == 4'd1) begin
        st = 4'd6; da = ir[7:0]; dwr = 1; ra = ir[11:8]; ra_en = 1;
      end else if (op == 4'd2) begin
        st = 4'd4; da = ir[11:4]; rfs = 1;
      end else if (op == 4'd3 || op == 4'd4) begin
        st = (op == 4'd3) ? 4'd7 : 4'd8;
        alu = (op == 4'd3) ? 3'b001 : 3'b010;
        ra = ir[11:8]; ra_en = 1; rb = ir[7:4]; rb_en = 1;
        w = ir[3:0]; w_en = 1;
      end else st = 4'd3;
    end
    return {st, hal, alu, rb_en, rb, ra_en, ra, w_en, w, rfs, dwr, da, ir, pc};
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_valid = 1; m_init = 1; m_halt = 0; m_step = 0; m_pc = 0; m_ir = 0;
    end else if (m_valid) begin
      if (m_init) begin
        m_init = 0; m_step = 0;
      end else if (!m_halt) begin
        if (m_step == 0) begin
          m_ir = rom[m_pc]; m_pc = m_pc + 7'd1; m_step = 1;
        end else if (m_step == 1) begin
          if (m_ir[15:12] == 4'd5) m_halt = 1;
          else m_step = 2;
        end else if (m_step == 2 && m_ir[15:12] == 4'd2) m_step = 3;
        else m_step = 0;
      end
    end
    #1;
    if (m_valid) begin
      m_exp = model_outputs(m_init, m_halt, m_step, m_ir, m_pc);
      chk("cycle", 64'({State, Halted, ALU_s, RF_Rb_en, RF_Rb_addr, RF_Ra_en,
                        RF_Ra_addr, RF_W_en, RF_W_addr, RF_s, D_wr, D_addr,
                        IR, PC_addr}), 64'(m_exp));
    end
  end

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int n = 0;
    while (State !== st && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(name, 64'(State), 64'(st));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h21B3; rom[1] = 16'h3125; rom[2] = 16'h4125;
    rom[3] = 16'h17A4; rom[4] = 16'hF000; rom[5] = 16'h5000;

    // Reset for two cycles, then step through the directed program.
    @(negedge Clk); Reset = 1;
    @(negedge Clk);
    @(negedge Clk); Reset = 0;
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_pc", 64'(PC_addr), 64'd0);
    chk("rst_en", 64'({RF_W_en, RF_Ra_en, RF_Rb_en, D_wr, Halted}), 64'd0);
    @(negedge Clk);
    chk("fetch0", 64'({State, PC_addr}), 64'({4'd1, 7'd0}));
    chk("fetch0_en", 64'({RF_W_en, RF_Ra_en, RF_Rb_en, D_wr}), 64'd0);
    @(negedge Clk);
    chk("decode0", 64'({State, PC_addr}), 64'({4'd2, 7'd1}));
    @(negedge Clk);
    chk("load_a", 64'({State, D_addr, RF_s, RF_W_en}), 64'({4'd4, 8'h1B, 1'b1, 1'b0}));
    chk("model_load_a", 64'(m_exp[55:52]), 64'd4);
    @(negedge Clk);
    chk("load_b", 64'({State, D_addr, RF_s, RF_W_en, RF_W_addr}),
        64'({4'd5, 8'h1B, 1'b1, 1'b1, 4'd3}));
    @(negedge Clk);
    chk("load_done", 64'(State), 64'd1);
    @(negedge Clk); @(negedge Clk);
    chk("add", 64'({State, RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_s, RF_s, RF_W_addr, RF_W_en}),
        64'({4'd7, 4'd1, 4'd2, 1'b1, 1'b1, 3'b001, 1'b0, 4'd5, 1'b1}));
    chk("model_add_alu", 64'(m_exp[50:48]), 64'd1);
    @(negedge Clk); @(negedge Clk); @(negedge Clk);
    chk("sub", 64'({State, RF_Ra_addr, RF_Rb_addr, ALU_s, RF_W_addr, RF_W_en}),
        64'({4'd8, 4'd1, 4'd2, 3'b010, 4'd5, 1'b1}));
    @(negedge Clk); @(negedge Clk); @(negedge Clk);
    chk("store", 64'({State, D_addr, D_wr, RF_Ra_addr, RF_Ra_en, RF_W_en}),
        64'({4'd6, 8'hA4, 1'b1, 4'd7, 1'b1, 1'b0}));
    @(negedge Clk);
    chk("opf_fetch", 64'(State), 64'd1);
    @(negedge Clk); @(negedge Clk);
    chk("opf_noop", 64'(State), 64'd3);
    @(negedge Clk);
    chk("opf_done", 64'(State), 64'd1);
    @(negedge Clk); @(negedge Clk);
    chk("halt", 64'({State, Halted}), 64'({4'd9, 1'b1}));
    repeat (22) @(negedge Clk);
    chk("halt_hold", 64'({State, Halted, PC_addr, IR}), 64'({4'd9, 1'b1, 7'd6, 16'h5000}));
    Reset = 1;
    @(negedge Clk); Reset = 0;
    chk("halt_reset", 64'({State, Halted, PC_addr}), 64'd0);

    // PC wrap: all-NOOP program until the fetch at 127, then expect 0.
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    @(negedge Clk);
    begin
      int n = 0;
      while (!(State == 4'd1 && PC_addr == 7'd127) && n < 600) begin
        @(negedge Clk);
        n++;
      end
      chk("reach_pc127", 64'({State, PC_addr}), 64'({4'd1, 7'd127}));
    end
    repeat (3) @(negedge Clk);
    chk("pc_wrap", 64'({State, PC_addr}), 64'({4'd1, 7'd0}));

    // Reset during LOAD_A must suppress the LOAD_B write.
    rom[0] = 16'h21B3;
    Reset = 1;
    @(negedge Clk); Reset = 0;
    wait_state(4'd4, 10, "reach_load_a");
    Reset = 1;
    @(negedge Clk); Reset = 0;
    chk("midload_reset", 64'({State, RF_W_en}), 64'({4'd0, 1'b0}));

    // Randomized programs with sporadic resets, checked against the model.
    for (int i = 0; i < 128; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5 && $urandom_range(0, 7) != 0) op = 4'd3;
      rom[i] = {op, 12'($urandom)};
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 49) == 0) rom[$urandom_range(0, 127)] = 16'($urandom);
    end
    @(negedge Clk); Reset = 0;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
